scan_test_ctrl: RTL

SCAN_TEST_CTRL -- requirements
Module: scan_test_ctrl

---
 rtl/scan_test_pkg.sv | 17 +
 rtl/scan_shift_reg.sv | 27 ++
 rtl/scan_test_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/scan_test_pkg.sv
// Shared constants and helpers for the scan test controller.
package scan_test_pkg;

    localparam int unsigned FAIL_CNT_W = 8;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SHIFT   = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_FLUSH   = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    // Saturating increment for the failing-pattern counter.
    function automatic logic [FAIL_CNT_W-1:0] sat_inc(input logic [FAIL_CNT_W-1:0] v);
        return (&v) ? v : v + FAIL_CNT_W'(1);
    endfunction

endpackage

// File: rtl/scan_shift_reg.sv
// Parallel-load / serial-shift register; shifts toward bit 0 with serial input at the MSB.
module scan_shift_reg #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         shift,
    input  logic         sin,
    output logic [W-1:0] q,
    output logic [W-1:0] q_shifted_c
);

    assign q_shifted_c = (q >> 1) | (W'(sin) << (W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= q_shifted_c;
        end
    end

endmodule

// File: rtl/scan_test_ctrl.sv
// Scan test sequencer: shifts patterns in, captures, unloads and compares responses.
module scan_test_ctrl
    import scan_test_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 3,
    parameter int unsigned PI_W      = 4,
    parameter int unsigned PO_W      = 1
) (
    input  logic                      CK,
    input  logic                      RST,
    input  logic                      pat_valid,
    output logic                      pat_ready,
    input  logic [CHAIN_LEN-1:0]      pat_si,
    input  logic [PI_W-1:0]           pat_pi,
    input  logic [CHAIN_LEN+PO_W-1:0] pat_exp,
    input  logic [CHAIN_LEN+PO_W-1:0] pat_mask,
    input  logic                      pat_last,
    output logic                      test_se,
    output logic                      test_si,
    input  logic                      test_so,
    output logic [PI_W-1:0]           pi,
    input  logic [PO_W-1:0]           po,
    output logic                      res_valid,
    output logic                      res_fail,
    output logic [FAIL_CNT_W-1:0]     fail_cnt,
    output logic                      done
);

    localparam int unsigned RW = CHAIN_LEN + PO_W;
    localparam int unsigned CW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CHAIN_LEN - 1);

    logic [2:0]           state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [RW-1:0]        cur_exp, cur_mask, cmp_exp, cmp_mask;
    logic                 cur_last, cur_last_n, cmp_valid, prev_q;
    logic [PI_W-1:0]      pend_pi;
    logic [RW-1:0]        pend_exp, pend_mask;
    logic                 pend_last, pend_valid;
    logic [PO_W-1:0]      po_cap;
    logic [CHAIN_LEN-1:0] si_q, si_shift_c, resp_q, resp_shift_c;
    logic [RW-1:0]        resp_full;
    logic                 accept, start_new, take_pend, start_pend, to_flush, to_idle;
    logic                 cmp_evt, mismatch, ready_n;
    logic                 sig_unused;

    assign accept     = pat_valid && pat_ready;
    assign test_si    = si_q[0];
    assign sig_unused = ^{si_q, si_shift_c, resp_q};

    scan_shift_reg #(.W(CHAIN_LEN)) u_si_reg (
        .clk         (CK),
        .rst         (RST),
        .load        (start_new || take_pend),
        .din         (pat_si),
        .shift       (state == ST_SHIFT),
        .sin         (1'b0),
        .q           (si_q),
        .q_shifted_c (si_shift_c)
    );

    scan_shift_reg #(.W(CHAIN_LEN)) u_resp_reg (
        .clk         (CK),
        .rst         (RST),
        .load        (1'b0),
        .din         ('0),
        .shift       ((state == ST_SHIFT) || (state == ST_FLUSH)),
        .sin         (test_so),
        .q           (resp_q),
        .q_shifted_c (resp_shift_c)
    );

    // Next state, transition strobes and compare of the response completing this cycle.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        start_new  = 1'b0;
        take_pend  = 1'b0;
        start_pend = 1'b0;
        to_flush   = 1'b0;
        to_idle    = 1'b0;
        cmp_evt    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_n   = ST_SHIFT;
                    cnt_n     = '0;
                    start_new = 1'b1;
                end
            end
            ST_SHIFT: begin
                take_pend = accept;
                if (cnt == CNT_LAST) begin
                    state_n = ST_CAPTURE;
                    cnt_n   = '0;
                    cmp_evt = cmp_valid;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ST_CAPTURE: begin
                cnt_n = '0;
                if (cur_last) begin
                    state_n  = ST_FLUSH;
                    to_flush = 1'b1;
                end else if (pend_valid) begin
                    state_n    = ST_SHIFT;
                    start_pend = 1'b1;
                end else begin
                    state_n = ST_IDLE;
                    to_idle = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (cnt == CNT_LAST) begin
                    state_n = ST_DONE;
                    cnt_n   = '0;
                    cmp_evt = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
        cur_last_n = start_new ? pat_last : (start_pend ? pend_last : cur_last);
        ready_n    = (state_n == ST_IDLE) || (state_n == ST_DONE) ||
                     ((state_n == ST_SHIFT) && (cnt_n == CNT_LAST) && !cur_last_n);
        resp_full  = {po_cap, resp_shift_c};
        mismatch   = |((resp_full ^ cmp_exp) & cmp_mask);
    end

    // cur_* is the pattern in SHIFT/CAPTURE, cmp_* the one whose response is unloading.
    always_ff @(posedge CK) begin
        if (RST) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            pat_ready  <= 1'b0;
            test_se    <= 1'b0;
            pi         <= '0;
            res_valid  <= 1'b0;
            res_fail   <= 1'b0;
            fail_cnt   <= '0;
            done       <= 1'b0;
            cur_exp    <= '0;
            cur_mask   <= '0;
            cur_last   <= 1'b0;
            cmp_exp    <= '0;
            cmp_mask   <= '0;
            cmp_valid  <= 1'b0;
            pend_pi    <= '0;
            pend_exp   <= '0;
            pend_mask  <= '0;
            pend_last  <= 1'b0;
            pend_valid <= 1'b0;
            prev_q     <= 1'b0;
            po_cap     <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            pat_ready <= ready_n;
            test_se   <= (state_n == ST_SHIFT) || (state_n == ST_FLUSH);
            done      <= (state_n == ST_DONE);
            res_valid <= cmp_evt;
            res_fail  <= cmp_evt && mismatch;
            cur_last  <= cur_last_n;
            if (start_new && (state == ST_DONE)) begin
                fail_cnt <= '0;
            end else if (cmp_evt && mismatch) begin
                fail_cnt <= sat_inc(fail_cnt);
            end
            if (start_new) begin
                pi        <= pat_pi;
                cur_exp   <= pat_exp;
                cur_mask  <= pat_mask;
                cmp_exp   <= cur_exp;
                cmp_mask  <= cur_mask;
                cmp_valid <= (state == ST_IDLE) && prev_q;
                prev_q    <= 1'b0;
            end
            if (take_pend) begin
                pend_pi    <= pat_pi;
                pend_exp   <= pat_exp;
                pend_mask  <= pat_mask;
                pend_last  <= pat_last;
                pend_valid <= 1'b1;
            end
            if (start_pend) begin
                pi         <= pend_pi;
                cur_exp    <= pend_exp;
                cur_mask   <= pend_mask;
                cmp_exp    <= cur_exp;
                cmp_mask   <= cur_mask;
                cmp_valid  <= 1'b1;
                pend_valid <= 1'b0;
            end
            if (to_flush) begin
                cmp_exp  <= cur_exp;
                cmp_mask <= cur_mask;
            end
            if (to_idle) begin
                prev_q <= 1'b1;
            end
            if (state == ST_CAPTURE) begin
                po_cap <= po;
            end
        end
    end

endmodule
